// File: rtl/quadencoder_pkg.sv
// Shared encoder-stage definitions: default widths, the velocity FSM state
// type and a saturating increment used by timers across the encoder chain.
package quadencoder_pkg;

  localparam int QENC_BITS_DEFAULT    = 32;
  localparam int QENC_TS_BITS_DEFAULT = 24;
  localparam int QENC_WINDOW_DEFAULT  = 50000;

  typedef enum logic {
    ST_RESYNC = 1'b0,
    ST_RUN    = 1'b1
  } qenc_state_e;

  // Increment that sticks at the all-ones value of a width-bit field.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int unsigned width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value >= max_val) ? max_val : value + 64'd1;
  endfunction

endpackage

// File: rtl/quadencoder_velocity_if.sv
// Host-side bundle of the velocity stage: position/index inputs from the
// encoder counter and the velocity/period/direction/stall results.
interface quadencoder_velocity_if
  import quadencoder_pkg::*;
#(
  parameter int BITS    = QENC_BITS_DEFAULT,
  parameter int TS_BITS = QENC_TS_BITS_DEFAULT
);

  logic               enable;
  logic [BITS-1:0]    position;
  logic               index_clear;
  logic [BITS-1:0]    velocity;
  logic               vel_valid;
  logic [TS_BITS-1:0] period;
  logic               period_valid;
  logic               direction;
  logic               stalled;

  modport master (
    output enable, position, index_clear,
    input  velocity, vel_valid, period, period_valid, direction, stalled
  );

  modport slave (
    input  enable, position, index_clear,
    output velocity, vel_valid, period, period_valid, direction, stalled
  );

endinterface

// File: rtl/quadencoder_velocity_period_timer.sv
// Low-speed measurement: cycles between successive position changes, with a
// saturating timer that doubles as the stall detector.
module qenc_period_timer
  import quadencoder_pkg::*;
#(
  parameter int BITS    = QENC_BITS_DEFAULT,
  parameter int TS_BITS = QENC_TS_BITS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               load,
  input  logic               run,
  input  logic [BITS-1:0]    position,
  output logic [TS_BITS-1:0] period,
  output logic               period_valid,
  output logic               direction,
  output logic               stalled
);

  localparam logic [TS_BITS-1:0] TS_MAX = '1;

  logic [BITS-1:0]    pos_prev;
  logic [TS_BITS-1:0] timer;
  logic [TS_BITS-1:0] timer_inc;
  logic [BITS-1:0]    step;

  always_comb begin
    timer_inc = TS_BITS'(sat_inc(64'(timer), TS_BITS));
    step      = position - pos_prev;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_prev     <= '0;
      timer        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      direction    <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!enable) begin
        timer   <= '0;
        stalled <= 1'b0;
      end else if (load) begin
        pos_prev <= position;
        timer    <= '0;
      end else if (run) begin
        pos_prev <= position;
        // A multi-count jump is still a single change event.
        if (position != pos_prev) begin
          period       <= timer_inc;
          timer        <= '0;
          direction    <= ~step[BITS-1];
          stalled      <= 1'b0;
          period_valid <= 1'b1;
        end else begin
          timer <= timer_inc;
          if (timer_inc == TS_MAX) stalled <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/quadencoder_velocity.sv
// Velocity stage downstream of the encoder counter: windowed velocity, plus
// period/direction/stall from qenc_period_timer. Optional IIR smoothing of
// the velocity is enabled by defining QENC_VEL_FILTER_EN.
//
// state     | meaning
// ST_RESYNC | next enabled cycle re-latches position references, no strobes
// ST_RUN    | window counting and change detection active
module quadencoder_velocity
  import quadencoder_pkg::*;
#(
  parameter int BITS          = QENC_BITS_DEFAULT,
  parameter int WINDOW_CYCLES = QENC_WINDOW_DEFAULT,
  parameter int TS_BITS       = QENC_TS_BITS_DEFAULT,
  parameter int FILTER_SHIFT  = 2
) (
  input logic                   clk,
  input logic                   rst_n,
  quadencoder_velocity_if.slave bus
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

  qenc_state_e state, state_next;
  logic        sync_cyc, run_cyc, window_end;

  logic [WIN_W-1:0]       win_cnt;
  logic [BITS-1:0]        pos_last;
  logic signed [BITS-1:0] vel_q;
  logic signed [BITS-1:0] vel_new;
  logic signed [BITS-1:0] delta;
  logic                   vel_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RESYNC;
    else        state <= state_next;
  end

  // index_clear outranks both the resync latch and the window terminal.
  always_comb begin
    state_next = state;
    sync_cyc   = 1'b0;
    run_cyc    = 1'b0;
    if (!bus.enable || bus.index_clear) begin
      state_next = ST_RESYNC;
    end else begin
      state_next = ST_RUN;
      sync_cyc   = (state == ST_RESYNC);
      run_cyc    = (state == ST_RUN);
    end
  end

  always_comb begin
    window_end = run_cyc && (win_cnt == WIN_LAST);
    delta      = $signed(bus.position - pos_last);
  end

`ifdef QENC_VEL_FILTER_EN
  logic signed [BITS-1:0] vel_err;
  always_comb begin
    vel_err = delta - vel_q;
    vel_new = vel_q + (vel_err >>> FILTER_SHIFT);
  end
`else
  logic unused_filter_shift;
  assign unused_filter_shift = ^FILTER_SHIFT;
  always_comb vel_new = delta;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_cnt     <= '0;
      pos_last    <= '0;
      vel_q       <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      vel_valid_q <= 1'b0;
      if (!bus.enable) begin
        win_cnt <= '0;
        vel_q   <= '0;
      end else if (sync_cyc) begin
        pos_last <= bus.position;
        win_cnt  <= '0;
`ifdef QENC_VEL_FILTER_EN
        vel_q    <= '0;
`endif
      end else if (run_cyc) begin
        if (window_end) begin
          vel_q       <= vel_new;
          pos_last    <= bus.position;
          win_cnt     <= '0;
          vel_valid_q <= 1'b1;
        end else begin
          win_cnt <= win_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.velocity  = $unsigned(vel_q);
  assign bus.vel_valid = vel_valid_q;

  qenc_period_timer #(
    .BITS    (BITS),
    .TS_BITS (TS_BITS)
  ) u_period_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (bus.enable),
    .load         (sync_cyc),
    .run          (run_cyc),
    .position     (bus.position),
    .period       (bus.period),
    .period_valid (bus.period_valid),
    .direction    (bus.direction),
    .stalled      (bus.stalled)
  );

endmodule
